// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PENDING = 2'd2
  } pc_state_e;

  localparam int PC_INCREASE = 4;

endpackage

// File: rtl/pc_redirect_sel.sv
// Redirect source select: jump beats branch. With PC_ALIGN_CHECK_EN defined,
// a target with nonzero low bits is rejected and reported through bad_target.
module pc_redirect_sel #(
  parameter int DATA_W = 16
) (
  input  logic              jump,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] jump_pc,
  input  logic [DATA_W-1:0] branch_pc,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_target,
  output logic              bad_target
);

  logic strobe;

  always_comb begin
    strobe          = jump | branch_taken;
    redirect_target = jump ? jump_pc : branch_pc;
`ifdef PC_ALIGN_CHECK_EN
    bad_target      = strobe && (redirect_target[1:0] != 2'b00);
    redirect_valid  = strobe && !bad_target;
`else
    bad_target      = 1'b0;
    redirect_valid  = strobe;
`endif
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: valid/ready fetch requests, +4 advance, redirects
// with one-cycle flush. Alignment rejection only when PC_ALIGN_CHECK_EN is defined.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic [DATA_W-1:0] branch_pc,
  input  logic [DATA_W-1:0] jump_pc,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [DATA_W-1:0] req_addr,
  output logic [DATA_W-1:0] updated_pc,
  output logic              flush,
  output logic              misaligned
);

  pc_state_e         state_reg, state_next;
  logic [DATA_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] updated_pc_reg, updated_pc_next;
  logic [DATA_W-1:0] latched_reg, latched_next;
  logic              valid_reg, valid_next;
  logic              flush_reg, flush_next;
  logic              misaligned_reg, misaligned_next;

  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_target;
  logic              bad_target;
  logic [DATA_W-1:0] pc_inc;
  logic              accept;

  pc_redirect_sel #(.DATA_W(DATA_W)) u_sel (
    .jump            (jump),
    .branch_taken    (branch_taken),
    .jump_pc         (jump_pc),
    .branch_pc       (branch_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .bad_target      (bad_target)
  );

  assign pc_inc = pc_reg + DATA_W'(PC_INCREASE);
  assign accept = valid_reg && req_ready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      updated_pc_reg <= RESET_PC + DATA_W'(PC_INCREASE);
      latched_reg    <= RESET_PC;
      valid_reg      <= 1'b0;
      flush_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      updated_pc_reg <= updated_pc_next;
      latched_reg    <= latched_next;
      valid_reg      <= valid_next;
      flush_reg      <= flush_next;
      misaligned_reg <= misaligned_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    updated_pc_next = updated_pc_reg;
    latched_next    = latched_reg;
    valid_next      = valid_reg;
    flush_next      = 1'b0;
    misaligned_next = bad_target;

    unique case (state_reg)
      IDLE: begin
        if (redirect_valid) pc_next = redirect_target;
        if (enable) state_next = FETCH;
      end
      FETCH: begin
        if (!valid_reg) begin
          // Nothing outstanding yet: a redirect may retarget freely before issue.
          if (redirect_valid) pc_next = redirect_target;
          if (enable) valid_next = 1'b1;
          else        state_next = IDLE;
        end else if (accept) begin
          updated_pc_next = pc_inc;
          pc_next         = redirect_valid ? redirect_target : pc_inc;
          flush_next      = redirect_valid;
          if (!enable) begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end else if (redirect_valid) begin
          latched_next = redirect_target;
          state_next   = PENDING;
        end
      end
      PENDING: begin
        if (redirect_valid) latched_next = redirect_target;
        if (accept) begin
          updated_pc_next = pc_inc;
          pc_next         = redirect_valid ? redirect_target : latched_reg;
          flush_next      = 1'b1;
          if (enable) begin
            state_next = FETCH;
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_valid  = valid_reg;
  assign req_addr   = pc_reg;
  assign updated_pc = updated_pc_reg;
  assign flush      = flush_reg;
  assign misaligned = misaligned_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: transaction-level reference model checked
// every cycle, plus directed literal expectations. Honours PC_ALIGN_CHECK_EN.
module tb_pc_sequencer;

  localparam int          W      = 16;
  localparam logic [15:0] RST_PC = 16'h0100;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          enable = 1'b0;
  logic          branch_taken = 1'b0;
  logic          jump = 1'b0;
  logic [W-1:0]  branch_pc = '0;
  logic [W-1:0]  jump_pc = '0;
  logic          req_ready = 1'b0;
  logic          req_valid;
  logic [W-1:0]  req_addr;
  logic [W-1:0]  updated_pc;
  logic          flush;
  logic          misaligned;

  int n_pass = 0;
  int n_total = 0;

  pc_sequencer #(.DATA_W(W), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .arst         (arst),
    .enable       (enable),
    .branch_taken (branch_taken),
    .jump         (jump),
    .branch_pc    (branch_pc),
    .jump_pc      (jump_pc),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .updated_pc   (updated_pc),
    .flush        (flush),
    .misaligned   (misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a request is either outstanding or not; once outstanding it
  // stays until accepted, and a redirect seen while it waits is remembered.
  logic         m_valid, m_armed, m_redir, m_flush, m_mis;
  logic [15:0]  m_addr, m_upd, m_tgt;

  always @(posedge clk or posedge arst) begin
    logic        strobe, ok;
    logic [15:0] tgt;
    if (arst) begin
      m_valid = 1'b0; m_armed = 1'b0; m_redir = 1'b0; m_flush = 1'b0; m_mis = 1'b0;
      m_addr = RST_PC; m_upd = RST_PC + 16'd4; m_tgt = RST_PC;
    end else begin
      strobe  = jump || branch_taken;
      tgt     = jump ? jump_pc : branch_pc;
      ok      = strobe && !(ALIGN && tgt[1:0] != 2'b00);
      m_mis   = strobe && !ok;
      m_flush = 1'b0;
      if (m_valid) begin
        if (req_ready) begin
          m_upd = m_addr + 16'd4;
          if (ok)           begin m_addr = tgt;   m_flush = 1'b1; end
          else if (m_redir) begin m_addr = m_tgt; m_flush = 1'b1; end
          else              m_addr = m_addr + 16'd4;
          m_redir = 1'b0;
          m_valid = enable;
          m_armed = enable;
        end else if (ok) begin
          m_redir = 1'b1;
          m_tgt   = tgt;
        end
      end else begin
        if (ok) m_addr = tgt;
        if (m_armed) m_valid = enable;
        m_armed = enable;
      end
    end
  end

  always @(negedge clk) begin
    if (!arst) begin
      check("model_req_valid", {15'd0, req_valid}, {15'd0, m_valid});
      check("model_req_addr", req_addr, m_addr);
      check("model_updated_pc", updated_pc, m_upd);
      check("model_flush", {15'd0, flush}, {15'd0, m_flush});
      check("model_misaligned", {15'd0, misaligned}, {15'd0, m_mis});
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #12;
    check("rst_req_valid", {15'd0, req_valid}, 16'd0);
    check("rst_req_addr", req_addr, 16'h0100);
    check("rst_updated_pc", updated_pc, 16'h0104);
    check("rst_flush", {15'd0, flush}, 16'd0);
    check("rst_misaligned", {15'd0, misaligned}, 16'd0);
    @(negedge clk);
    arst = 1'b0; enable = 1'b1; req_ready = 1'b1;
    step(1);
    check("first_edge_no_valid", {15'd0, req_valid}, 16'd0);
    step(1);
    check("issue_valid", {15'd0, req_valid}, 16'd1);
    check("issue_0100", req_addr, 16'h0100);
    step(1);
    check("seq_0104", req_addr, 16'h0104);
    check("upd_after_0100", updated_pc, 16'h0104);

    // Stall at 0x0104 for three edges; enable drops mid-wait.
    req_ready = 1'b0;
    step(1);
    enable = 1'b0;
    check("stall_valid_1", {15'd0, req_valid}, 16'd1);
    check("stall_addr_1", req_addr, 16'h0104);
    step(1);
    check("stall_valid_2", {15'd0, req_valid}, 16'd1);
    check("stall_addr_2", req_addr, 16'h0104);
    step(1);
    check("stall_valid_3", {15'd0, req_valid}, 16'd1);
    enable = 1'b1; req_ready = 1'b1;
    step(1);
    check("seq_0108", req_addr, 16'h0108);
    check("upd_0108", updated_pc, 16'h0108);

    // Branch in the acceptance cycle of 0x0108.
    branch_taken = 1'b1; branch_pc = 16'h0200;
    step(1);
    branch_taken = 1'b0;
    check("branch_addr", req_addr, 16'h0200);
    check("branch_flush", {15'd0, flush}, 16'd1);
    check("branch_upd", updated_pc, 16'h010C);
    step(1);
    check("flush_one_cycle", {15'd0, flush}, 16'd0);
    check("after_branch", req_addr, 16'h0204);

    // Redirects during a stall: latest target wins.
    req_ready = 1'b0; jump = 1'b1; jump_pc = 16'h0300;
    step(1);
    jump = 1'b0; branch_taken = 1'b1; branch_pc = 16'h0400;
    check("pend_addr_stable_1", req_addr, 16'h0204);
    step(1);
    branch_taken = 1'b0; req_ready = 1'b1;
    check("pend_addr_stable_2", req_addr, 16'h0204);
    step(1);
    check("pend_target", req_addr, 16'h0400);
    check("pend_flush", {15'd0, flush}, 16'd1);
    check("pend_upd", updated_pc, 16'h0208);
    step(1);
    check("pend_flush_off", {15'd0, flush}, 16'd0);

    // Jump and branch together: jump wins.
    jump = 1'b1; jump_pc = 16'h0500; branch_taken = 1'b1; branch_pc = 16'h0600;
    step(1);
    branch_taken = 1'b0; jump_pc = 16'hFFFC;
    check("jump_priority", req_addr, 16'h0500);
    step(1);
    jump = 1'b0;
    check("at_fffc", req_addr, 16'hFFFC);
    step(1);
    check("wrap_addr", req_addr, 16'h0000);
    check("wrap_upd", updated_pc, 16'h0000);

    // Misaligned jump target.
    jump = 1'b1; jump_pc = 16'h0202;
    step(1);
    jump = 1'b0;
    if (ALIGN) begin
      check("align_ignored", req_addr, 16'h0004);
      check("align_mis", {15'd0, misaligned}, 16'd1);
    end else begin
      check("noalign_used", req_addr, 16'h0202);
      check("noalign_mis", {15'd0, misaligned}, 16'd0);
    end
    step(1);
    check("mis_one_cycle", {15'd0, misaligned}, 16'd0);

    // Reset in the middle of a stalled request.
    req_ready = 1'b0;
    #2 arst = 1'b1;
    #1;
    check("midrst_valid", {15'd0, req_valid}, 16'd0);
    check("midrst_addr", req_addr, 16'h0100);
    check("midrst_flush", {15'd0, flush}, 16'd0);
    @(negedge clk);
    arst = 1'b0; enable = 1'b0; jump = 1'b1; jump_pc = 16'h0800;
    step(1);
    jump = 1'b0;
    check("idle_redirect_addr", req_addr, 16'h0800);
    check("idle_redirect_noflush", {15'd0, flush}, 16'd0);
    enable = 1'b1; req_ready = 1'b1;
    step(2);
    check("idle_issue", req_addr, 16'h0800);
    check("idle_issue_valid", {15'd0, req_valid}, 16'd1);
    step(1);
    check("idle_seq", req_addr, 16'h0804);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
